// File: rtl/exec_muldiv_if.sv
// rtl/exec_muldiv_if.sv - request/result bundle between the execute-stage controller and exec_muldiv
//
// Purpose : groups the multiply/divide request, HI/LO move and status signals.
// Modports: master (controller side) drives i_* and reads o_*;
//           slave  (exec_muldiv) reads i_* and drives o_*.
// Signals : i_start, i_op[1:0], i_a_in, i_b_in, i_mthi, i_mtlo,
//           o_busy, o_done, o_div_zero, o_hi, o_lo.
interface exec_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             i_start;
  logic [1:0]       i_op;
  logic [WIDTH-1:0] i_a_in;
  logic [WIDTH-1:0] i_b_in;
  logic             i_mthi;
  logic             i_mtlo;
  logic             o_busy;
  logic             o_done;
  logic             o_div_zero;
  logic [WIDTH-1:0] o_hi;
  logic [WIDTH-1:0] o_lo;

  modport master (
    output i_start, i_op, i_a_in, i_b_in, i_mthi, i_mtlo,
    input  o_busy, o_done, o_div_zero, o_hi, o_lo
  );

  modport slave (
    input  i_start, i_op, i_a_in, i_b_in, i_mthi, i_mtlo,
    output o_busy, o_done, o_div_zero, o_hi, o_lo
  );
endinterface

// File: rtl/exec_muldiv.sv
// rtl/exec_muldiv.sv - iterative mult/multu/div/divu unit with HI/LO registers
//
// Purpose : multi-cycle multiply/divide beside the execute-stage ALU. Operands are
//           reduced to magnitudes at start, iterated in CALC (shift-add multiply,
//           restoring divide), sign-corrected and written to HI/LO in FIX.
// Ports   : i_clock  - rising-edge clock
//           i_reset  - asynchronous active-high reset
//           bus      - exec_muldiv_if.slave (start/op/operands/mthi/mtlo in,
//                      busy/done/div_zero/hi/lo out)
// Op code : 00 mult, 01 multu, 10 div, 11 divu
// Option  : MULDIV_FAST_MUL_EN - multiplies use a single-cycle combinational
//           product (IDLE -> FIX); divides stay iterative.
module exec_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic         i_clock,
  input  logic         i_reset,
  exec_muldiv_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_acc;       // mult: {partial sum, multiplier}; div: low half = dividend/quotient
  logic [WIDTH-1:0]     r_rem;       // divide partial remainder
  logic [WIDTH-1:0]     r_opnd;      // mult: multiplicand magnitude; div: divisor magnitude
  logic                 r_is_div;
  logic                 r_neg_q;     // negate product / quotient
  logic                 r_neg_r;     // negate remainder (dividend sign)
  logic                 r_b_zero;
  logic                 r_done;
  logic                 r_div_zero;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  logic                 w_signed;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_shift;
  logic [WIDTH:0]       w_diff;
  logic                 w_qbit;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quo;
  logic [WIDTH-1:0]     w_rmd;

  assign w_signed = ~bus.i_op[0];
  assign w_a_neg  = w_signed & bus.i_a_in[WIDTH-1];
  assign w_b_neg  = w_signed & bus.i_b_in[WIDTH-1];
  assign w_a_mag  = w_a_neg ? (~bus.i_a_in + 1'b1) : bus.i_a_in;
  assign w_b_mag  = w_b_neg ? (~bus.i_b_in + 1'b1) : bus.i_b_in;

  // Shift-add step: conditionally add the multiplicand into the upper half,
  // then shift the whole accumulator right keeping the carry.
  assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};

  // Restoring divide step: a negative trial difference means "restore".
  assign w_shift  = {r_rem, r_acc[WIDTH-1]};
  assign w_diff   = w_shift - {1'b0, r_opnd};
  assign w_qbit   = ~w_diff[WIDTH];

  assign w_prod   = r_neg_q ? (~r_acc + 1'b1) : r_acc;
  assign w_quo    = r_neg_q ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
  assign w_rmd    = r_neg_r ? (~r_rem + 1'b1) : r_rem;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fast_prod;
  assign w_fast_prod = {{WIDTH{1'b0}}, w_a_mag} * {{WIDTH{1'b0}}, w_b_mag};
`endif

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.i_start) begin
`ifdef MULDIV_FAST_MUL_EN
          w_next = bus.i_op[1] ? S_CALC : S_FIX;
`else
          w_next = S_CALC;
`endif
        end
      end
      S_CALC:  if (r_cnt == CNT_W'(1)) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_rem      <= '0;
      r_opnd     <= '0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_b_zero   <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Moves land first; a simultaneous start overwrites HI/LO at completion.
          if (bus.i_mthi) r_hi <= bus.i_a_in;
          if (bus.i_mtlo) r_lo <= bus.i_a_in;
          if (bus.i_start) begin
            r_is_div   <= bus.i_op[1];
            r_neg_q    <= w_a_neg ^ w_b_neg;
            r_neg_r    <= w_a_neg;
            r_b_zero   <= bus.i_op[1] & (bus.i_b_in == '0);
            r_div_zero <= 1'b0;
            r_cnt      <= CNT_W'(WIDTH);
            r_rem      <= '0;
            if (bus.i_op[1]) begin
              r_opnd <= w_b_mag;
              r_acc  <= {{WIDTH{1'b0}}, w_a_mag};
            end else begin
              r_opnd <= w_a_mag;
`ifdef MULDIV_FAST_MUL_EN
              r_acc  <= w_fast_prod;
`else
              r_acc  <= {{WIDTH{1'b0}}, w_b_mag};
`endif
            end
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_is_div) begin
            r_rem <= w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
            r_acc <= {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-2:0], w_qbit};
          end else if (r_acc[0]) begin
            r_acc <= {w_sum, r_acc[WIDTH-1:1]};
          end else begin
            r_acc <= {1'b0, r_acc[2*WIDTH-1:1]};
          end
        end
        S_FIX: begin
          r_done <= 1'b1;
          if (r_is_div) begin
            // Zero divisor: the remainder path already rebuilds the dividend.
            r_hi       <= w_rmd;
            r_lo       <= r_b_zero ? {WIDTH{1'b1}} : w_quo;
            r_div_zero <= r_b_zero;
          end else begin
            {r_hi, r_lo} <= w_prod;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_busy     = (r_state != S_IDLE);
  assign bus.o_done     = r_done;
  assign bus.o_div_zero = r_div_zero;
  assign bus.o_hi       = r_hi;
  assign bus.o_lo       = r_lo;

endmodule

// File: tb/tb_exec_muldiv.sv
// tb/tb_exec_muldiv.sv - directed self-checking bench for exec_muldiv (WIDTH=32)
module tb_exec_muldiv;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   n;
  logic seen_done;

  exec_muldiv_if #(.WIDTH(32)) bus ();

  exec_muldiv #(.WIDTH(32)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.i_start = 1'b1;
    bus.i_op    = op;
    bus.i_a_in  = a;
    bus.i_b_in  = b;
    step();
    bus.i_start = 1'b0;
  endtask

  // Waits (bounded) for busy to drop, returns the number of busy samples seen.
  task automatic finish_op(input string tag, output int cnt);
    cnt = 0;
    while (bus.o_busy === 1'b1 && cnt < 100) begin
      cnt++;
      step();
    end
    check({tag, "_done"}, 64'(bus.o_done), 64'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_op    = 2'b00;
    bus.i_a_in  = '0;
    bus.i_b_in  = '0;
    bus.i_mthi  = 1'b0;
    bus.i_mtlo  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_busy", 64'(bus.o_busy), 64'd0);
    check("rst_done", 64'(bus.o_done), 64'd0);
    check("rst_dz",   64'(bus.o_div_zero), 64'd0);
    check("rst_hi",   64'(bus.o_hi), 64'd0);
    check("rst_lo",   64'(bus.o_lo), 64'd0);

    // mult -3 * 7
    launch(2'b00, 32'hFFFFFFFD, 32'd7);
    finish_op("mult", n);
    check("mult_busy_cycles", 64'(n), 64'd33);
    check("mult_hi", 64'(bus.o_hi), 64'hFFFFFFFF);
    check("mult_lo", 64'(bus.o_lo), 64'hFFFFFFEB);
    step();
    check("mult_done_pulse", 64'(bus.o_done), 64'd0);

    // multu max * max
    launch(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    finish_op("multu", n);
    check("multu_hi", 64'(bus.o_hi), 64'hFFFFFFFE);
    check("multu_lo", 64'(bus.o_lo), 64'h00000001);

    // div -7 / 2, then divu on the same bits
    launch(2'b10, 32'hFFFFFFF9, 32'd2);
    finish_op("div", n);
    check("div_lo", 64'(bus.o_lo), 64'hFFFFFFFD);
    check("div_hi", 64'(bus.o_hi), 64'hFFFFFFFF);
    launch(2'b11, 32'hFFFFFFF9, 32'd2);
    finish_op("divu", n);
    check("divu_lo", 64'(bus.o_lo), 64'h7FFFFFFC);
    check("divu_hi", 64'(bus.o_hi), 64'h00000001);

    // divide by zero, then a start clears the sticky flag
    launch(2'b11, 32'h00001234, 32'd0);
    finish_op("divz", n);
    check("divz_cycles", 64'(n), 64'd33);
    check("divz_hi", 64'(bus.o_hi), 64'h00001234);
    check("divz_lo", 64'(bus.o_lo), 64'hFFFFFFFF);
    check("divz_flag", 64'(bus.o_div_zero), 64'd1);
    launch(2'b00, 32'd2, 32'd3);
    check("dz_cleared", 64'(bus.o_div_zero), 64'd0);
    finish_op("mul23", n);
    check("mul23_lo", 64'(bus.o_lo), 64'd6);
    check("mul23_hi", 64'(bus.o_hi), 64'd0);

    // div 100/7 with start and mthi attempted mid-CALC
    launch(2'b10, 32'd100, 32'd7);
    repeat (3) step();
    bus.i_start = 1'b1;
    bus.i_op    = 2'b00;
    bus.i_a_in  = 32'h000000AA;
    bus.i_mthi  = 1'b1;
    step();
    bus.i_start = 1'b0;
    bus.i_mthi  = 1'b0;
    check("calc_hold_hi", 64'(bus.o_hi), 64'd0);
    check("calc_hold_lo", 64'(bus.o_lo), 64'd6);
    check("calc_busy", 64'(bus.o_busy), 64'd1);
    finish_op("div100", n);
    check("div100_lo", 64'(bus.o_lo), 64'd14);
    check("div100_hi", 64'(bus.o_hi), 64'd2);

    // reset during a second divide
    launch(2'b10, 32'd100, 32'd7);
    repeat (9) step();
    rst = 1'b1;
    #1;
    check("abort_busy", 64'(bus.o_busy), 64'd0);
    check("abort_hi", 64'(bus.o_hi), 64'd0);
    check("abort_lo", 64'(bus.o_lo), 64'd0);
    step();
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.o_done === 1'b1) seen_done = 1'b1;
    end
    check("abort_no_done", 64'(seen_done), 64'd0);
    check("abort_hi_after", 64'(bus.o_hi), 64'd0);

    // signed overflow
    launch(2'b10, 32'h80000000, 32'hFFFFFFFF);
    finish_op("ovf", n);
    check("ovf_lo", 64'(bus.o_lo), 64'h80000000);
    check("ovf_hi", 64'(bus.o_hi), 64'd0);
    check("ovf_dz", 64'(bus.o_div_zero), 64'd0);

    // register moves in IDLE
    bus.i_a_in = 32'h00000055;
    bus.i_mtlo = 1'b1;
    step();
    bus.i_mtlo = 1'b0;
    check("mtlo_lo", 64'(bus.o_lo), 64'h55);
    check("mtlo_hi", 64'(bus.o_hi), 64'd0);
    bus.i_a_in = 32'h00000099;
    bus.i_mthi = 1'b1;
    bus.i_mtlo = 1'b1;
    step();
    bus.i_mthi = 1'b0;
    bus.i_mtlo = 1'b0;
    check("mtboth_hi", 64'(bus.o_hi), 64'h99);
    check("mtboth_lo", 64'(bus.o_lo), 64'h99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_muldiv.md
Name: exec_muldiv

Overview:
- Parametrised multi-cycle multiply/divide companion to the single-cycle 32-bit ALU in the execute stage.
- Executes mult, multu, div and divu iteratively into a HI/LO register pair. Also supports mfhi/mflo reads and mthi/mtlo writes.
- Exposes a busy/done handshake so the controller stalls the pipeline while an operation runs.

Parameters:
- WIDTH, 32, operand, HI and LO width (>= 4).
- CNT_W, $clog2(WIDTH+1), iteration-counter width (derived; do not override).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request; sampled only when busy=0.
- op  in  2  00 mult, 01 multu, 10 div, 11 divu; sampled with start.
- a_in  in  WIDTH  rs operand (multiplicand / dividend).
- b_in  in  WIDTH  rt operand (multiplier / divisor).
- mthi  in  1  write a_in to HI; ignored while busy.
- mtlo  in  1  write a_in to LO; ignored while busy.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when HI/LO are updated by an operation.
- div_zero  out  1  sticky; set by div/divu with b_in=0, cleared by the next accepted start.
- hi  out  WIDTH  HI register (mfhi source).
- lo  out  WIDTH  LO register (mflo source).

Behaviour:
- Reset values: busy=0, done=0, div_zero=0, hi=0, lo=0, state=IDLE, counter=0. Reset mid-operation aborts the operation; no partial result is written.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE:
  - start=1 at edge E0 latches the operands as magnitudes (signed ops take the absolute value) and latches the result signs.
  - Loads counter=WIDTH and enters CALC.
  - mthi/mtlo in the same cycle as start are applied first; the operation then overwrites HI/LO at completion.
  - mthi and mtlo together write both registers.
- CALC: one iteration per cycle. Counter decrements; at counter=1 the state moves to FIX.
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring algorithm with a WIDTH+1-bit partial remainder.
- FIX: applies sign correction, writes {HI,LO}, pulses done, and returns to IDLE.
- Latency: start at E0; HI/LO written at edge E(WIDTH+1); done high for the cycle after E(WIDTH+1).
- busy is high from after E0 until after E(WIDTH+1). A new start is accepted in the cycle done is high.
- start while busy=1 is ignored (not queued). mthi/mtlo while busy=1 are ignored.
- hi/lo hold their old values throughout CALC.
- Multiply: {HI,LO} = full 2*WIDTH product. mult is signed two's complement; multu is unsigned.
- Divide: LO=quotient, HI=remainder. Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
- Signed overflow (-2^(WIDTH-1) / -1): LO=-2^(WIDTH-1), HI=0, no flag.
- Divisor zero: the operation still takes full latency. Result HI=a_in, LO=all ones, and div_zero is set at E(WIDTH+1).
- Unsigned ops never sign-correct. op=multu/divu with a top-bit-set operand is treated as a large positive value.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- When defined: mult/multu use a combinational WIDTH x WIDTH product registered directly. The path is IDLE -> FIX at E0; HI/LO are written at E1, done is high the cycle after E1, and busy is high for one cycle. Divide is unchanged.
- When undefined: all ops use the iterative path with WIDTH+1 cycle latency as above.

Test Plan:
- WIDTH=32, mult a=0xFFFFFFFD (-3), b=7 -> after 33 cycles done pulses; HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy high exactly 33 cycles.
- multu a=0xFFFFFFFF, b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. With MULDIV_FAST_MUL_EN, same values and done in the cycle after E1.
- div a=-7 (0xFFFFFFF9), b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu on the same operands -> LO=0x7FFFFFFC, HI=1.
- divu a=0x1234, b=0 -> HI=0x1234, LO=0xFFFFFFFF, div_zero=1. Next start of mult 2x3 clears div_zero and gives LO=6, HI=0.
- Start div 100/7, then pulse start (mult) and mthi (a=0xAA) mid-CALC -> both ignored; result LO=14, HI=2. Reset asserted at cycle 10 of a second div -> busy=0, hi=lo=0 immediately, no done pulse.
- div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0, div_zero=0. mtlo a=0x55 in IDLE -> lo=0x55 next cycle, hi unchanged.
